// File: rtl/rob_drain_scheduler_if.sv
// Request-accept and ROB read-port signal bundle of the drain scheduler.
interface rob_drain_scheduler_if #(
  parameter int unsigned ROW_W = 11
);
  logic             iReqValid;
  logic [ROW_W-1:0] iReqRow;
  logic             oReqReady;
  logic             iFlush;
  logic             oROB_Rd;
  logic [ROW_W-1:0] oROB_Row;
  logic             iROB_ItemValid;
  logic             iROB_ItemEnd;
  logic             oDrainDone;
  logic [3:0]       oDrainCnt;
  logic             oDrainErr;
  logic             oTableFull;
  logic             oBusy;

  // Controller / ROB side driving the scheduler.
  modport master (
    output iReqValid, iReqRow, iFlush, iROB_ItemValid, iROB_ItemEnd,
    input  oReqReady, oROB_Rd, oROB_Row, oDrainDone, oDrainCnt, oDrainErr,
           oTableFull, oBusy
  );

  // The scheduler itself.
  modport slave (
    input  iReqValid, iReqRow, iFlush, iROB_ItemValid, iROB_ItemEnd,
    output oReqReady, oROB_Rd, oROB_Row, oDrainDone, oDrainCnt, oDrainErr,
           oTableFull, oBusy
  );
endinterface

// File: rtl/rob_drain_scheduler.sv
// ROB drain scheduler: tracks pending rows in a small CAM, picks a row to
// drain, issues the ROB read and supervises the returned item burst.
module rob_drain_scheduler #(
  parameter int unsigned ROW_W   = 11,
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned WAYS    = 8,
  parameter int unsigned AGE_MAX = 63,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 resetn,
  rob_drain_scheduler_if.slave bus
);
  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned CNT_W = $clog2(WAYS + 1);
  localparam int unsigned AGE_W = 6;
  localparam int unsigned TMR_W = 4;
  localparam int unsigned ITM_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RELEASE} state_e;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ROW_W-1:0]   row_q [ENTRIES];
  logic [ROW_W-1:0]   row_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_d [ENTRIES];
  logic [AGE_W-1:0]   age_q [ENTRIES];
  logic [AGE_W-1:0]   age_d [ENTRIES];
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic [CNT_W-1:0]   exp_cnt_q, exp_cnt_d;
  logic [ITM_W-1:0]   item_cnt_q, item_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               rd_q, rd_d, done_q, done_d, err_q, err_d;
  logic               busy_q, busy_d, full_q, full_d;
  logic [ROW_W-1:0]   rob_row_q, rob_row_d;
  logic [ITM_W-1:0]   drain_cnt_q, drain_cnt_d;

  logic               hit_c, free_ok_c, req_ready_c, full_c, sel_ok_c;
  logic [IDX_W-1:0]   hit_idx_c, free_idx_c, sel_idx_c;
  logic [CNT_W-1:0]   best_cnt_c;

  assign full_c = &valid_q;

  // CAM lookup of the incoming row and the accept decision.
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_ok_c  = 1'b0;
    free_idx_c = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (!hit_c && valid_q[i] && (row_q[i] == bus.iReqRow)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
      if (!free_ok_c && !valid_q[i]) begin
        free_ok_c  = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
    if (hit_c) begin
      req_ready_c = (cnt_q[hit_idx_c] < CNT_W'(WAYS)) &&
                    !((state_q != S_IDLE) && (hit_idx_c == sel_idx_q));
    end else begin
      req_ready_c = free_ok_c;
    end
  end

  // Drain candidate: full row, then aged row, then flush, then fullest row.
  always_comb begin
    sel_ok_c   = 1'b0;
    sel_idx_c  = '0;
    best_cnt_c = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (!sel_ok_c && valid_q[i] && (cnt_q[i] == CNT_W'(WAYS))) begin
        sel_ok_c  = 1'b1;
        sel_idx_c = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (!sel_ok_c && valid_q[i] && (age_q[i] >= AGE_W'(AGE_MAX))) begin
        sel_ok_c  = 1'b1;
        sel_idx_c = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (!sel_ok_c && bus.iFlush && valid_q[i]) begin
        sel_ok_c  = 1'b1;
        sel_idx_c = IDX_W'(i);
      end
    end
    if (!sel_ok_c && full_c) begin
      sel_ok_c   = 1'b1;
      best_cnt_c = cnt_q[0];
      for (int i = 1; i < int'(ENTRIES); i++) begin
        if (cnt_q[i] > best_cnt_c) begin
          best_cnt_c = cnt_q[i];
          sel_idx_c  = IDX_W'(i);
        end
      end
    end
  end

  // Table maintenance, drain FSM next-state and registered output values.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    age_d       = age_q;
    sel_idx_d   = sel_idx_q;
    exp_cnt_d   = exp_cnt_q;
    item_cnt_d  = item_cnt_q;
    timer_d     = timer_q;
    rob_row_d   = rob_row_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (valid_q[i] && (age_q[i] != '1)) age_d[i] = age_q[i] + AGE_W'(1);
    end

    if (bus.iReqValid && req_ready_c) begin
      if (hit_c) begin
        cnt_d[hit_idx_c] = cnt_q[hit_idx_c] + CNT_W'(1);
      end else begin
        valid_d[free_idx_c] = 1'b1;
        row_d[free_idx_c]   = bus.iReqRow;
        cnt_d[free_idx_c]   = CNT_W'(1);
        age_d[free_idx_c]   = '0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sel_ok_c) begin
          state_d   = S_ISSUE;
          sel_idx_d = sel_idx_c;
          rob_row_d = row_q[sel_idx_c];
        end
      end
      S_ISSUE: begin
        exp_cnt_d  = cnt_q[sel_idx_q];
        item_cnt_d = '0;
        timer_d    = '0;
        state_d    = S_DRAIN;
      end
      S_DRAIN: begin
        item_cnt_d = item_cnt_q + ITM_W'(bus.iROB_ItemValid);
        timer_d    = timer_q + TMR_W'(1);
        if (bus.iROB_ItemEnd) begin
          state_d     = S_RELEASE;
          done_d      = 1'b1;
          drain_cnt_d = item_cnt_d;
          err_d       = 32'(item_cnt_d) != 32'(exp_cnt_q);
        end else if (timer_d == TMR_W'(TIMEOUT)) begin
          state_d     = S_RELEASE;
          done_d      = 1'b1;
          drain_cnt_d = item_cnt_d;
          err_d       = 1'b1;
        end
      end
      S_RELEASE: begin
        valid_d[sel_idx_q] = 1'b0;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rd_d   = (state_d == S_ISSUE);
    busy_d = (state_d != S_IDLE);
    full_d = &valid_d;
  end

  // State and table registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        row_q[i] <= '0;
        cnt_q[i] <= '0;
        age_q[i] <= '0;
      end
      sel_idx_q   <= '0;
      exp_cnt_q   <= '0;
      item_cnt_q  <= '0;
      timer_q     <= '0;
      rd_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      rob_row_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      age_q       <= age_d;
      sel_idx_q   <= sel_idx_d;
      exp_cnt_q   <= exp_cnt_d;
      item_cnt_q  <= item_cnt_d;
      timer_q     <= timer_d;
      rd_q        <= rd_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      rob_row_q   <= rob_row_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign bus.oReqReady  = req_ready_c;
  assign bus.oROB_Rd    = rd_q;
  assign bus.oROB_Row   = rob_row_q;
  assign bus.oDrainDone = done_q;
  assign bus.oDrainCnt  = drain_cnt_q;
  assign bus.oDrainErr  = err_q;
  assign bus.oTableFull = full_q;
  assign bus.oBusy      = busy_q;
endmodule

// File: tb/tb_rob_drain_scheduler.sv
// Bench for rob_drain_scheduler: directed scenarios plus randomized traffic
// checked cycle by cycle against a row-table reference model.
module tb_rob_drain_scheduler;
  localparam int unsigned ROW_W = 11;
  localparam int NE = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rob_drain_scheduler_if #(.ROW_W(ROW_W)) bus ();

  rob_drain_scheduler #(
    .ROW_W(ROW_W), .ENTRIES(4), .WAYS(8), .AGE_MAX(63), .TIMEOUT(15)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  // reference model: row table and drain progress
  bit               m_valid [NE];
  logic [ROW_W-1:0] m_row [NE];
  int               m_cnt [NE];
  int               m_age [NE];
  bit               m_busy, m_rel;
  int               m_since, m_idx, m_items, m_timer, m_exp;
  bit               e_rd, e_done, e_err, e_busy, e_full;
  logic [ROW_W-1:0] e_row;
  int               e_cnt;

  // ROB responder plan
  int plan_mode, plan_n, rsp_left;
  bit plan_gaps, noise, rand_plan, rsp_end;

  // observations
  int               cyc;
  logic             last_ready;
  bit               acc_seen, rd_seen, done_seen;
  int               acc_cyc, rd_cyc, done_cyc, dcnt;
  bit               derr;
  logic [ROW_W-1:0] rd_row;
  int               done_rows[$];
  int               done_errs[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_find(input logic [ROW_W-1:0] r);
    for (int i = 0; i < NE; i++) if (m_valid[i] && m_row[i] == r) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < NE; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic bit m_ready(input logic [ROW_W-1:0] r);
    int h;
    h = m_find(r);
    if (h >= 0) return (m_cnt[h] < 8) && !(m_busy && h == m_idx);
    return m_free() >= 0;
  endfunction

  function automatic int m_pick(input bit flush);
    int best;
    for (int i = 0; i < NE; i++) if (m_valid[i] && m_cnt[i] == 8) return i;
    for (int i = 0; i < NE; i++) if (m_valid[i] && m_age[i] >= 63) return i;
    if (flush) for (int i = 0; i < NE; i++) if (m_valid[i]) return i;
    if (m_free() < 0) begin
      best = 0;
      for (int i = 1; i < NE; i++) if (m_cnt[i] > m_cnt[best]) best = i;
      return best;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0; m_row[i] = '0; m_cnt[i] = 0; m_age[i] = 0;
    end
    m_busy = 0; m_rel = 0; m_since = 0; m_idx = 0; m_items = 0; m_timer = 0; m_exp = 0;
    e_rd = 0; e_done = 0; e_err = 0; e_busy = 0; e_full = 0; e_row = '0; e_cnt = 0;
    rsp_left = 0; rsp_end = 0;
  endtask

  // One clock edge of the reference model, using the inputs of the ending cycle.
  task automatic model_step();
    bit acc;
    int hi, fi, si;
    hi  = m_find(bus.iReqRow);
    fi  = m_free();
    acc = bus.iReqValid && m_ready(bus.iReqRow);
    si  = m_busy ? -1 : m_pick(bus.iFlush);
    e_done = 0;
    e_err  = 0;
    for (int i = 0; i < NE; i++) if (m_valid[i] && m_age[i] < 63) m_age[i]++;
    if (m_busy) begin
      if (m_rel) begin
        m_valid[m_idx] = 0; m_busy = 0; m_rel = 0;
      end else if (m_since == 1) begin
        m_since = 2; m_exp = m_cnt[m_idx]; m_items = 0; m_timer = 0;
      end else begin
        if (bus.iROB_ItemValid) m_items = (m_items + 1) % 16;
        m_timer++;
        if (bus.iROB_ItemEnd || m_timer == 15) begin
          m_rel  = 1;
          e_done = 1;
          e_cnt  = m_items;
          e_err  = !bus.iROB_ItemEnd || (m_items != m_exp);
        end
      end
    end else if (si >= 0) begin
      m_busy = 1; m_since = 1; m_idx = si; e_row = m_row[si];
    end
    if (acc) begin
      if (hi >= 0) m_cnt[hi]++;
      else begin
        m_valid[fi] = 1; m_row[fi] = bus.iReqRow; m_cnt[fi] = 1; m_age[fi] = 0;
      end
    end
    e_rd   = m_busy && (m_since == 1);
    e_busy = m_busy;
    e_full = 1;
    for (int i = 0; i < NE; i++) if (!m_valid[i]) e_full = 0;
  endtask

  // Drives the ROB item lines for the current cycle from the responder plan.
  task automatic drive_rob();
    int r;
    bus.iROB_ItemValid = 1'b0;
    bus.iROB_ItemEnd   = 1'b0;
    if (m_busy && m_since == 1) begin
      if (rand_plan) begin
        r = $urandom_range(0, 19);
        plan_mode = (r < 12) ? 0 : ((r < 17) ? 1 : 2);
        plan_n    = $urandom_range(0, 9);
      end
      case (plan_mode)
        0:       begin rsp_left = m_cnt[m_idx]; rsp_end = 1; end
        1:       begin rsp_left = plan_n;       rsp_end = 1; end
        default: begin rsp_left = 0;            rsp_end = 0; end
      endcase
    end else if (m_busy && !m_rel) begin
      if (rsp_left > 0) begin
        if (!plan_gaps || $urandom_range(0, 2) != 0) begin
          bus.iROB_ItemValid = 1'b1;
          rsp_left--;
          if (rsp_left == 0 && rsp_end) begin
            bus.iROB_ItemEnd = 1'b1;
            rsp_end = 0;
          end
        end
      end else if (rsp_end) begin
        bus.iROB_ItemEnd = 1'b1;
        rsp_end = 0;
      end
    end
    if (noise && !(m_busy && m_since >= 2 && !m_rel) && $urandom_range(0, 5) == 0) begin
      bus.iROB_ItemValid = 1'($urandom_range(0, 1));
      bus.iROB_ItemEnd   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_outputs();
    check_eq("rob_rd", bus.oROB_Rd, e_rd);
    check_eq("rob_row", bus.oROB_Row, e_row);
    check_eq("drain_done", bus.oDrainDone, e_done);
    check_eq("drain_cnt", bus.oDrainCnt, e_cnt);
    check_eq("drain_err", bus.oDrainErr, e_err);
    check_eq("table_full", bus.oTableFull, e_full);
    check_eq("busy", bus.oBusy, e_busy);
    if (bus.oROB_Rd) begin rd_seen = 1; rd_cyc = cyc; rd_row = bus.oROB_Row; end
    if (bus.oDrainDone) begin
      done_seen = 1; done_cyc = cyc; dcnt = bus.oDrainCnt; derr = bus.oDrainErr;
      done_rows.push_back(int'(bus.oROB_Row));
      done_errs.push_back(int'(bus.oDrainErr));
    end
  endtask

  // One clock cycle: request inputs already set by the caller.
  task automatic tick();
    drive_rob();
    #1;
    last_ready = bus.oReqReady;
    check_eq("req_ready", bus.oReqReady, m_ready(bus.iReqRow));
    if (bus.iReqValid && bus.oReqReady) begin acc_seen = 1; acc_cyc = cyc; end
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic req_n(input logic [ROW_W-1:0] r, input int n);
    bus.iReqValid = 1'b1;
    bus.iReqRow   = r;
    repeat (n) tick();
    bus.iReqValid = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    tick();
    while ((bus.oBusy || m_busy) && n < max_cyc) begin tick(); n++; end
    check_eq(tag, bus.oBusy, 1'b0);
  endtask

  task automatic clear_table();
    int n;
    bit any;
    n = 0;
    bus.iReqValid = 1'b0; bus.iFlush = 1'b1;
    plan_mode = 0; rand_plan = 0; noise = 0; plan_gaps = 0;
    do begin
      tick(); n++;
      any = m_busy;
      for (int i = 0; i < NE; i++) any |= m_valid[i];
    end while (any && n < 300);
    bus.iFlush = 1'b0;
    tick();
    check_eq("clear_busy", bus.oBusy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.iReqValid = 1'b0; bus.iReqRow = '0; bus.iFlush = 1'b0;
    bus.iROB_ItemValid = 1'b0; bus.iROB_ItemEnd = 1'b0;
    plan_mode = 0; plan_n = 0; plan_gaps = 0; noise = 0; rand_plan = 0;
    cyc = 0; acc_seen = 0; rd_seen = 0; done_seen = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_rd", bus.oROB_Rd, 1'b0);
    check_eq("rst_busy", bus.oBusy, 1'b0);
    check_eq("rst_full", bus.oTableFull, 1'b0);
    check_eq("rst_done", bus.oDrainDone, 1'b0);
    check_eq("rst_row", bus.oROB_Row, 0);
    check_eq("rst_cnt", bus.oDrainCnt, 0);
    check_eq("rst_ready", bus.oReqReady, 1'b1);
    @(negedge clk);
    resetn = 1'b1;

    // eight requests to one row fill it and trigger the drain
    req_n(11'h012, 8);
    rd_seen = 0; done_seen = 0;
    run_until_idle("s1_bound", 40);
    check_eq("s1_rd_row", rd_row, 11'h012);
    check_eq("s1_done", done_seen, 1'b1);
    check_eq("s1_cnt", dcnt, 8);
    check_eq("s1_err", derr, 1'b0);

    // full table: fullest row drains, blocked miss accepted after release
    clear_table();
    req_n(11'd1, 1); req_n(11'd2, 3); req_n(11'd3, 2); req_n(11'd4, 1);
    rd_seen = 0; done_seen = 0; acc_seen = 0;
    bus.iReqValid = 1'b1; bus.iReqRow = 11'd5;
    tick();
    check_eq("s2_refuse5", last_ready, 1'b0);
    for (int n = 0; n < 40 && !acc_seen; n++) tick();
    bus.iReqValid = 1'b0;
    check_eq("s2_acc5", acc_seen, 1'b1);
    check_eq("s2_rd_row", rd_row, 11'd2);
    check_eq("s2_cnt", dcnt, 3);
    check_eq("s2_acc_cyc", acc_cyc, done_cyc + 1);

    // aged single request drains on its own
    clear_table();
    acc_seen = 0; rd_seen = 0;
    req_n(11'h7FF, 1);
    for (int n = 0; n < 90 && !rd_seen; n++) tick();
    check_eq("s3_rd_row", rd_row, 11'h7FF);
    check_eq("s3_latency", rd_cyc - acc_cyc, 65);
    run_until_idle("s3_bound", 40);

    // drain without end marker times out; same-row request waits
    clear_table();
    plan_mode = 2;
    req_n(11'd9, 8);
    acc_seen = 0; rd_seen = 0; done_seen = 0;
    bus.iReqValid = 1'b1; bus.iReqRow = 11'd9;
    for (int n = 0; n < 60 && !acc_seen; n++) tick();
    bus.iReqValid = 1'b0;
    check_eq("s4_err", derr, 1'b1);
    check_eq("s4_timeout", done_cyc - rd_cyc, 16);
    check_eq("s4_acc_after", acc_cyc, done_cyc + 1);

    // flush drains entries in index order; short burst flags an error
    clear_table();
    plan_mode = 1; plan_n = 1;
    req_n(11'd1, 2); req_n(11'd3, 1);
    done_rows.delete(); done_errs.delete();
    bus.iFlush = 1'b1;
    for (int n = 0; n < 60 && done_rows.size() < 2; n++) tick();
    bus.iFlush = 1'b0;
    repeat (2) tick();
    check_eq("s5_ndone", done_rows.size(), 2);
    if (done_rows.size() >= 2) begin
      check_eq("s5_row0", done_rows[0], 1);
      check_eq("s5_err0", done_errs[0], 1);
      check_eq("s5_row1", done_rows[1], 3);
      check_eq("s5_err1", done_errs[1], 0);
    end
    check_eq("s5_busy", bus.oBusy, 1'b0);
    check_eq("s5_full", bus.oTableFull, 1'b0);

    // reset in the middle of a drain
    clear_table();
    plan_mode = 2;
    req_n(11'h055, 8);
    repeat (6) tick();
    check_eq("s6_busy_pre", bus.oBusy, 1'b1);
    resetn = 1'b0;
    #1;
    check_eq("s6_rd", bus.oROB_Rd, 1'b0);
    check_eq("s6_busy", bus.oBusy, 1'b0);
    check_eq("s6_full", bus.oTableFull, 1'b0);
    check_eq("s6_done", bus.oDrainDone, 1'b0);
    check_eq("s6_ready", bus.oReqReady, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    plan_mode = 0;
    req_n(11'h055, 1);
    repeat (3) tick();

    // randomized traffic
    rand_plan = 1; noise = 1; plan_gaps = 1;
    for (int k = 0; k < 1500; k++) begin
      bus.iReqValid = 1'($urandom_range(0, 1));
      bus.iReqRow   = ($urandom_range(0, 9) == 0) ? ROW_W'($urandom) : ROW_W'($urandom_range(1, 6));
      bus.iFlush    = ($urandom_range(0, 19) == 0);
      tick();
    end
    clear_table();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/rob_drain_scheduler.md
Name: rob_drain_scheduler

Overview:
Sequences reads out of the reorder buffer. Tracks which DRAM rows have pending reordered requests, in a small content-addressed table of row, per-row count and age. Decides when to drain a row and which one, issues the single-cycle ROB read for that row, then monitors the returned item burst until its end marker. Sits between the request-accept path of the memory access controller and the reorder processor's read port.

Parameters:
ROW_W, 11, DRAM row address width
ENTRIES, 4, number of rows tracked concurrently (power of 2, 2..8)
WAYS, 8, ROB ways per row; maximum requests per row
AGE_MAX, 63, age at which an entry is force-drained (6-bit saturating age counter)
TIMEOUT, 15, cycles allowed in DRAIN without iROB_ItemEnd (4-bit counter)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
iReqValid  in  1  request being written into ROB this cycle
iReqRow  in  ROW_W  row of that request
oReqReady  out  1  request accepted when iReqValid&oReqReady (combinational)
iFlush  in  1  level: drain every valid entry regardless of thresholds
oROB_Rd  out  1  one-cycle read strobe to ROB
oROB_Row  out  ROW_W  row being read; held stable from ISSUE until RELEASE
iROB_ItemValid  in  1  ROB item strobe
iROB_ItemEnd  in  1  ROB last-item marker
oDrainDone  out  1  one-cycle pulse at end of drain
oDrainCnt  out  4  items counted in finished drain; valid with oDrainDone
oDrainErr  out  1  one-cycle pulse: drain timed out or count mismatch
oTableFull  out  1  all ENTRIES valid
oBusy  out  1  FSM not IDLE

Behaviour:
- Reset: all entries invalid, FSM IDLE. oROB_Rd, oDrainDone, oDrainErr, oBusy, oTableFull = 0. oROB_Row, oDrainCnt = 0. oReqReady follows its equation, so it reads 1 out of reset.
- Entry fields: valid, row, cnt (0..WAYS), age (6b, saturating).
- oReqReady = 1 if one of the following holds:
  - iReqRow hits a valid entry with cnt<WAYS that is not the entry being drained;
  - it misses and a free entry exists.
  Otherwise it is 0.
- Accept on a hit: cnt+1.
- Accept on a miss: allocate the lowest-index free entry with cnt=1, age=0.
- Age increments each cycle while valid; it saturates at 63.
- Selection in IDLE, evaluated every cycle; first rule that matches wins, lowest index breaks ties:
  - (a) cnt==WAYS;
  - (b) age>=AGE_MAX;
  - (c) iFlush with any valid entry;
  - (d) oTableFull: choose max cnt.
  - No match: stay in IDLE.
- FSM:
  - IDLE -> ISSUE on select: latch entry index and expected cnt, drive oROB_Row=row.
  - ISSUE: oROB_Rd=1 for exactly one cycle -> DRAIN. Clear item counter and timer.
  - DRAIN:
    - increment item counter (4b) on each iROB_ItemValid;
    - timer increments each cycle;
    - iROB_ItemEnd -> RELEASE;
    - timer==TIMEOUT -> RELEASE with error.
  - RELEASE (1 cycle):
    - invalidate the entry;
    - oDrainDone=1 and oDrainCnt = counter, including a ValidItem coincident with End;
    - oDrainErr=1 if timeout, or if counter != latched cnt;
    - -> IDLE.
- Latency: select to oROB_Rd = 1 cycle. End to oDrainDone = 1 cycle. Minimum IDLE->IDLE time = 4 cycles plus burst.
- Enqueue during a drain: requests to other rows proceed normally. Requests to the row being drained get oReqReady=0 until RELEASE completes; the entry becomes free the following cycle.
- A free entry freed in RELEASE is not allocatable in that same cycle.
- Items arriving outside DRAIN are ignored.
- iFlush deasserted mid-drain: the current drain completes.
- Async reset mid-drain: everything returns to reset values immediately; no oDrainDone is emitted.

Test Plan:
- 8 requests to row 0x012 on consecutive cycles -> entry cnt reaches 8; next cycle oROB_Rd=1 with oROB_Row=0x012. Model returns 8 items with End on the 8th -> oDrainDone=1, oDrainCnt=8, oDrainErr=0.
- 4 misses to rows 1,2,3,4 with counts 1,3,2,1 -> oTableFull=1, oReqReady=0 for row 5. Row 2 is drained first. Row 5 is accepted one cycle after RELEASE.
- Single request to row 0x7FF, idle for 63 cycles -> age rule fires and oROB_Rd pulses for 0x7FF.
- Drain in progress on row 9 with no ItemEnd -> after 15 DRAIN cycles, oDrainErr=1 and oDrainDone=1. A new request to row 9 is refused during the drain and accepted afterwards.
- iFlush with rows 1 (cnt 2) and 3 (cnt 1) -> two drains in index order, then oBusy=0 and oTableFull=0. Item count 1 returned for row 1 -> oDrainErr=1.
- resetn low during DRAIN -> oROB_Rd=0, oBusy=0 and all entries invalid. After release of reset, oReqReady=1.
